proj_select_ctrl: RTL and testbench

Wishbone-programmable controller that decides which one of `NUM_PROJECTS` wrapped user projects drives the shared user-area outputs. It produces the per-project `active` enables consumed by each project wrapper's tristate buffers, so that at most one project is ever enabled. It enforces break-before-make: every enable is low for a programmable guard interval before a new project is enabled. It sits in the user area beside the wrappers, on the same Wishbone slave bus.

---
 rtl/proj_select_ctrl_if.sv | 22 ++
 rtl/proj_select_ctrl.sv | 158 +++++++++++++++
 tb/tb_proj_select_ctrl.sv | 206 ++++++++++++++++++++
 3 files changed

// File: rtl/proj_select_ctrl_if.sv
// Wishbone slave-side bus bundle for proj_select_ctrl.
// The slave modport is used by the controller; the master modport is used by whatever drives the bus.
interface proj_select_ctrl_if;
    logic        wbs_stb_i;
    logic        wbs_cyc_i;
    logic        wbs_we_i;
    logic [3:0]  wbs_sel_i;
    logic [31:0] wbs_adr_i;
    logic [31:0] wbs_dat_i;
    logic        wbs_ack_o;
    logic [31:0] wbs_dat_o;

    modport slave (
        input  wbs_stb_i, wbs_cyc_i, wbs_we_i, wbs_sel_i, wbs_adr_i, wbs_dat_i,
        output wbs_ack_o, wbs_dat_o
    );

    modport master (
        output wbs_stb_i, wbs_cyc_i, wbs_we_i, wbs_sel_i, wbs_adr_i, wbs_dat_i,
        input  wbs_ack_o, wbs_dat_o
    );
endinterface

// File: rtl/proj_select_ctrl.sv
// Selects which user project drives the shared outputs, with a break-before-make guard.
// Optional macro PROJ_SELECT_LA_OVERRIDE_EN lets the logic analyzer take over the target.
module proj_select_ctrl #(
    parameter int          NUM_PROJECTS = 8,
    parameter int          GUARD_CYCLES = 4,
    parameter logic [31:0] BASE_ADDR    = 32'h3000_0000
) (
    input  logic                    wb_clk_i,
    input  logic                    wb_rst_ni,
    proj_select_ctrl_if.slave       wbs,
    input  logic                    la_override_i,
    input  logic [4:0]              la_sel_i,
    output logic [NUM_PROJECTS-1:0] active_o
);
    typedef enum logic [1:0] {ST_IDLE, ST_ON, ST_DRAIN} state_e;

    state_e                  state_q, state_d;
    logic [4:0]              cur_q, cur_d;
    logic [7:0]              cnt_q, cnt_d;
    logic                    ctrl_en_q, ctrl_en_d;
    logic [4:0]              ctrl_sel_q, ctrl_sel_d;
    logic                    err_q, err_d;
    logic                    ack_q, ack_d;
    logic [31:0]             dat_q, dat_d;
    logic [NUM_PROJECTS-1:0] active_q, active_d;
    logic [NUM_PROJECTS-1:0] onehot_cur;

    logic       hit, acc, wr_ctrl, wr_stat;
    logic [5:0] offset;
    logic       tgt_valid;
    logic [4:0] tgt_idx;
    logic [31:0] status_word;
    logic       unused_ok;

    function automatic logic in_range(input logic [4:0] idx);
        return {27'b0, idx} < NUM_PROJECTS;
    endfunction

    assign hit     = wbs.wbs_cyc_i & wbs.wbs_stb_i & (wbs.wbs_adr_i[31:8] == BASE_ADDR[31:8]);
    assign acc     = hit & ~ack_q;
    assign offset  = wbs.wbs_adr_i[7:2];
    assign wr_ctrl = acc & wbs.wbs_we_i & (offset == 6'd0);
    assign wr_stat = acc & wbs.wbs_we_i & (offset == 6'd1);

    // CUR field only meaningful while a project is actually enabled
    assign status_word = {21'b0, err_q, (state_q == ST_DRAIN), (state_q == ST_ON), 3'b0,
                          (state_q == ST_ON) ? cur_q : 5'd0};

    assign unused_ok = &{1'b0, wbs.wbs_sel_i, wbs.wbs_adr_i[1:0], wbs.wbs_dat_i,
                         la_override_i, la_sel_i};

    always_comb begin
        ctrl_en_d  = ctrl_en_q;
        ctrl_sel_d = ctrl_sel_q;
        err_d      = err_q;
        ack_d      = hit & ~ack_q;
        dat_d      = 32'h0;
        if (wr_ctrl) begin
            if (wbs.wbs_dat_i[31] && !in_range(wbs.wbs_dat_i[4:0])) begin
                err_d = 1'b1;
            end else begin
                ctrl_en_d  = wbs.wbs_dat_i[31];
                ctrl_sel_d = wbs.wbs_dat_i[4:0];
            end
        end
        if (wr_stat && wbs.wbs_dat_i[10]) begin
            err_d = 1'b0;
        end
        if (acc && !wbs.wbs_we_i) begin
            case (offset)
                6'd0:    dat_d = {ctrl_en_q, 26'b0, ctrl_sel_q};
                6'd1:    dat_d = status_word;
                default: dat_d = 32'h0;
            endcase
        end
    end

    always_comb begin
        tgt_valid = ctrl_en_q;
        tgt_idx   = ctrl_sel_q;
`ifdef PROJ_SELECT_LA_OVERRIDE_EN
        // out-of-range analyzer index means "nothing selected", not an error
        if (la_override_i) begin
            tgt_idx   = la_sel_i;
            tgt_valid = in_range(la_sel_i);
        end
`else
`endif
    end

    always_comb begin
        state_d = state_q;
        cur_d   = cur_q;
        cnt_d   = cnt_q;
        case (state_q)
            ST_IDLE: begin
                if (tgt_valid) begin
                    state_d = ST_ON;
                    cur_d   = tgt_idx;
                end
            end
            ST_ON: begin
                if (!tgt_valid || (tgt_idx != cur_q)) begin
                    state_d = ST_DRAIN;
                    cnt_d   = 8'(GUARD_CYCLES - 1);
                end
            end
            ST_DRAIN: begin
                // target may change mid-guard; the count keeps running regardless
                if (cnt_q == 8'd0) begin
                    if (tgt_valid) begin
                        state_d = ST_ON;
                        cur_d   = tgt_idx;
                    end else begin
                        state_d = ST_IDLE;
                    end
                end else begin
                    cnt_d = cnt_q - 8'd1;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    for (genvar gi = 0; gi < NUM_PROJECTS; gi++) begin : g_onehot
        assign onehot_cur[gi] = (cur_d == 5'(gi));
    end

    assign active_d = (state_d == ST_ON) ? onehot_cur : '0;

    always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
        if (!wb_rst_ni) begin
            state_q    <= ST_IDLE;
            cur_q      <= 5'd0;
            cnt_q      <= 8'd0;
            ctrl_en_q  <= 1'b0;
            ctrl_sel_q <= 5'd0;
            err_q      <= 1'b0;
            ack_q      <= 1'b0;
            dat_q      <= 32'h0;
            active_q   <= '0;
        end else begin
            state_q    <= state_d;
            cur_q      <= cur_d;
            cnt_q      <= cnt_d;
            ctrl_en_q  <= ctrl_en_d;
            ctrl_sel_q <= ctrl_sel_d;
            err_q      <= err_d;
            ack_q      <= ack_d;
            dat_q      <= dat_d;
            active_q   <= active_d;
        end
    end

    assign wbs.wbs_ack_o = ack_q;
    assign wbs.wbs_dat_o = dat_q;
    assign active_o      = active_q;
endmodule

// File: tb/tb_proj_select_ctrl.sv
// Scoreboard bench for proj_select_ctrl: expected read data and per-cycle enables are queued
// at stimulus time and compared by a negedge monitor.
module tb_proj_select_ctrl;
    localparam int          NP   = 8;
    localparam int          GC   = 4;
    localparam logic [31:0] BASE = 32'h3000_0000;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       la_ovr = 1'b0;
    logic [4:0] la_sel = 5'd0;
    logic [7:0] active;

    proj_select_ctrl_if bus();

    proj_select_ctrl #(
        .NUM_PROJECTS(NP),
        .GUARD_CYCLES(GC),
        .BASE_ADDR(BASE)
    ) dut (
        .wb_clk_i(clk),
        .wb_rst_ni(rst_n),
        .wbs(bus),
        .la_override_i(la_ovr),
        .la_sel_i(la_sel),
        .active_o(active)
    );

    always #5 clk = ~clk;

    int          n_chk = 0;
    int          n_pass = 0;
    logic [31:0] rd_q[$];
    logic [7:0]  act_q[$];
    logic [7:0]  act_exp = 8'h00;
    bit          mon_en = 1'b0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, got, exp);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic push_act(input logic [7:0] v, input int n);
        repeat (n) act_q.push_back(v);
    endtask

    task automatic bus_idle();
        bus.wbs_cyc_i = 1'b0;
        bus.wbs_stb_i = 1'b0;
        bus.wbs_we_i  = 1'b0;
        bus.wbs_sel_i = 4'h0;
        bus.wbs_adr_i = 32'h0;
        bus.wbs_dat_i = 32'h0;
    endtask

    // Holds the strobe until ack or a 4-cycle budget; returns in the ack cycle.
    task automatic wb_xfer(input logic [31:0] adr, input logic we, input logic [31:0] wdat,
                           input bit exp_ack, input logic [31:0] exp_rd);
        bit got;
        got = 1'b0;
        if (exp_ack) rd_q.push_back(we ? 32'h0 : exp_rd);
        bus.wbs_cyc_i = 1'b1;
        bus.wbs_stb_i = 1'b1;
        bus.wbs_we_i  = we;
        bus.wbs_sel_i = 4'hf;
        bus.wbs_adr_i = adr;
        bus.wbs_dat_i = wdat;
        for (int i = 0; i < 4 && !got; i++) begin
            step();
            got = bus.wbs_ack_o;
        end
        bus_idle();
        chk("ack", 32'(got), 32'(exp_ack));
        $display("wb %s adr=0x%08h wdat=0x%08h ack=%0d", we ? "wr" : "rd", adr, wdat, got);
    endtask

    always @(negedge clk) begin
        if (mon_en) begin
            if (!rst_n) begin
                act_exp = 8'h00;
            end else begin
                if (act_q.size() > 0) act_exp = act_q.pop_front();
                chk("active", 32'(active), 32'(act_exp));
                chk("onehot0", 32'($onehot0(active)), 32'd1);
                if (bus.wbs_ack_o) begin
                    chk("ack_expected", 32'(rd_q.size() > 0), 32'd1);
                    if (rd_q.size() > 0) chk("rdata", bus.wbs_dat_o, rd_q.pop_front());
                end else begin
                    chk("dat_idle", bus.wbs_dat_o, 32'h0);
                end
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout, expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        bus_idle();
        repeat (3) @(posedge clk);
        #1;
        chk("rst_active", 32'(active), 32'h0);
        chk("rst_ack", 32'(bus.wbs_ack_o), 32'h0);
        chk("rst_dat", bus.wbs_dat_o, 32'h0);
        #2 rst_n = 1'b1;
        mon_en = 1'b1;
        step();

        // reset STATUS, then IDLE -> project 3
        wb_xfer(BASE + 32'h4, 1'b0, 32'h0, 1'b1, 32'h0);
        wb_xfer(BASE, 1'b1, 32'h8000_0003, 1'b1, 32'h0);
        push_act(8'h00, 1); push_act(8'h08, 1);
        step();
        wb_xfer(BASE + 32'h4, 1'b0, 32'h0, 1'b1, 32'h103);

        // 3 -> 5 with a full guard; BUSY sampled inside the guard
        wb_xfer(BASE, 1'b1, 32'h8000_0005, 1'b1, 32'h0);
        push_act(8'h08, 1); push_act(8'h00, 4); push_act(8'h20, 1);
        step();
        wb_xfer(BASE + 32'h4, 1'b0, 32'h0, 1'b1, 32'h200);
        wb_xfer(BASE + 32'h4, 1'b0, 32'h0, 1'b1, 32'h200);
        wb_xfer(BASE + 32'h4, 1'b0, 32'h0, 1'b1, 32'h105);

        // retarget at guard cycle 2: 3 never appears, 1 lands at the original guard end
        wb_xfer(BASE, 1'b1, 32'h8000_0003, 1'b1, 32'h0);
        push_act(8'h20, 1); push_act(8'h00, 1);
        wb_xfer(BASE, 1'b1, 32'h8000_0001, 1'b1, 32'h0);
        push_act(8'h00, 3); push_act(8'h02, 1);
        repeat (4) step();

        // out-of-range select sets ERR, CTRL unchanged; W1C clears it
        wb_xfer(BASE, 1'b1, 32'h8000_0009, 1'b1, 32'h0);
        wb_xfer(BASE + 32'h4, 1'b0, 32'h0, 1'b1, 32'h501);
        wb_xfer(BASE, 1'b0, 32'h0, 1'b1, 32'h8000_0001);
        wb_xfer(BASE + 32'h4, 1'b1, 32'h400, 1'b1, 32'h0);
        wb_xfer(BASE + 32'h4, 1'b0, 32'h0, 1'b1, 32'h101);

        // window boundaries
        wb_xfer(BASE + 32'h100, 1'b0, 32'h0, 1'b0, 32'h0);
        wb_xfer(BASE + 32'h10, 1'b0, 32'h0, 1'b1, 32'h0);
        wb_xfer(BASE + 32'h10, 1'b1, 32'hffff_ffff, 1'b1, 32'h0);
        wb_xfer(BASE, 1'b0, 32'h0, 1'b1, 32'h8000_0001);

        // ON -> none, then back to IDLE after the guard
        wb_xfer(BASE, 1'b1, 32'h0, 1'b1, 32'h0);
        push_act(8'h02, 1); push_act(8'h00, 1);
        repeat (4) step();
        wb_xfer(BASE + 32'h4, 1'b0, 32'h0, 1'b1, 32'h200);
        wb_xfer(BASE + 32'h4, 1'b0, 32'h0, 1'b1, 32'h000);

        // IDLE -> project 6
        wb_xfer(BASE, 1'b1, 32'h8000_0006, 1'b1, 32'h0);
        push_act(8'h00, 1); push_act(8'h40, 1);
        repeat (2) step();

        // asynchronous reset during a guard with a read ack on the bus
        wb_xfer(BASE, 1'b1, 32'h8000_0002, 1'b1, 32'h0);
        push_act(8'h40, 1); push_act(8'h00, 1);
        step();
        bus.wbs_cyc_i = 1'b1;
        bus.wbs_stb_i = 1'b1;
        bus.wbs_we_i  = 1'b0;
        bus.wbs_adr_i = BASE + 32'h4;
        @(posedge clk);
        #2;
        bus_idle();
        rst_n = 1'b0;
        #1;
        chk("arst_active", 32'(active), 32'h0);
        chk("arst_ack", 32'(bus.wbs_ack_o), 32'h0);
        chk("arst_dat", bus.wbs_dat_o, 32'h0);
        repeat (2) @(posedge clk);
        #3 rst_n = 1'b1;
        step();
        wb_xfer(BASE, 1'b0, 32'h0, 1'b1, 32'h0);
        wb_xfer(BASE + 32'h4, 1'b0, 32'h0, 1'b1, 32'h0);

`ifdef PROJ_SELECT_LA_OVERRIDE_EN
        wb_xfer(BASE, 1'b1, 32'h8000_0003, 1'b1, 32'h0);
        push_act(8'h00, 1); push_act(8'h08, 1);
        repeat (3) step();
        la_sel = 5'd6;
        la_ovr = 1'b1;
        push_act(8'h08, 1); push_act(8'h00, 4); push_act(8'h40, 1);
        repeat (7) step();
        la_ovr = 1'b0;
        push_act(8'h40, 1); push_act(8'h00, 4); push_act(8'h08, 1);
        repeat (7) step();
`endif

        repeat (2) step();
        chk("rd_q_drained", 32'(rd_q.size()), 32'd0);
        chk("act_q_drained", 32'(act_q.size()), 32'd0);
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
